// File: rtl/ctrl_unit.sv
// ---------------------------------------------------------------------------
// ctrl_unit -- sequencer for a small accumulator CPU.
//
// Runs a two-cycle FETCH/EXEC loop over a 32-byte program memory. FETCH
// latches the opcode byte into IR and bumps PC. EXEC decodes IR into
// one-cycle datapath strobes. Two-byte instructions (LDI, JMP, branch) read
// their operand from pm_data_cu at the current PC during EXEC. Opcode F
// parks the unit in HALT until reset.
//
// Optional build macro: CU_SINGLESTEP_EN
//   Adds the step_cu input and a STEP state. After every non-HALT EXEC the
//   unit waits in STEP, with all strobes low, until step_cu is sampled high.
//
// Ports
//   clk_cu        in   clock, rising edge
//   rst_cu        in   asynchronous active-low reset
//   step_cu       in   single-step release (CU_SINGLESTEP_EN builds only)
//   pm_addr_cu    out  [4:0] program memory address (= PC)
//   pm_data_cu    in   [7:0] program memory byte at pm_addr_cu
//   zero_cu       in   accumulator-is-zero flag (branch EXEC only)
//   positive_cu   in   accumulator-is-positive flag (branch EXEC only)
//   muxsel_cu     out  [1:0] 00 shifter, 01 regfile, 10 input, 11 immediate
//   imm_cu        out  [7:0] immediate byte (LDI only)
//   accwr_cu      out  accumulator write strobe
//   rfwr_cu       out  register file write strobe
//   outen_cu      out  output port enable strobe
//   rfaddr_cu     out  [2:0] register select (IR[2:0] during EXEC)
//   alusel_cu     out  [2:0] ALU operation
//   shiftsel_cu   out  [1:0] shifter operation
//   halted_cu     out  high once the HALT opcode is executing or halted
//
// Handshake: there is no valid/ready flow control. The program memory is
// an asynchronous read, so pm_data_cu must be valid in the same cycle that
// pm_addr_cu is presented. Strobes are single-cycle pulses that the datapath
// acts on at the next rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ctrl_unit (
    input  logic       clk_cu,
    input  logic       rst_cu,
`ifdef CU_SINGLESTEP_EN
    input  logic       step_cu,
`endif
    output logic [4:0] pm_addr_cu,
    input  logic [7:0] pm_data_cu,
    input  logic       zero_cu,
    input  logic       positive_cu,
    output logic [1:0] muxsel_cu,
    output logic [7:0] imm_cu,
    output logic       accwr_cu,
    output logic       rfwr_cu,
    output logic       outen_cu,
    output logic [2:0] rfaddr_cu,
    output logic [2:0] alusel_cu,
    output logic [1:0] shiftsel_cu,
    output logic       halted_cu
);

`ifdef CU_SINGLESTEP_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic       branch_taken;

    assign opcode       = ir_q[7:4];
    // IR[0] selects the flag: 0 = branch on zero, 1 = branch on positive.
    assign branch_taken = ir_q[0] ? positive_cu : zero_cu;
    assign pm_addr_cu   = pc_q;

    // Next-state logic. PC arithmetic is 5 bits wide, so 31 wraps to 0.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                ir_d    = pm_data_cu;
                pc_d    = pc_q + 5'd1;
                state_d = EXEC;
            end
            EXEC: begin
`ifdef CU_SINGLESTEP_EN
                state_d = STEP;
`else
                state_d = FETCH;
`endif
                case (opcode)
                    4'h3: pc_d = pc_q + 5'd1;           // skip LDI operand
                    4'hD: pc_d = pm_data_cu[4:0];       // JMP target
                    4'hE: pc_d = branch_taken ? pm_data_cu[4:0]
                                              : pc_q + 5'd1;
                    4'hF: state_d = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                state_d = HALT;
            end
`ifdef CU_SINGLESTEP_EN
            STEP: begin
                if (step_cu) begin
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // Output decode. Everything defaults low; only EXEC drives strobes, so
    // FETCH, HALT and STEP can never issue a write whatever the memory holds.
    always_comb begin
        muxsel_cu   = 2'b00;
        imm_cu      = 8'h00;
        accwr_cu    = 1'b0;
        rfwr_cu     = 1'b0;
        outen_cu    = 1'b0;
        rfaddr_cu   = 3'b000;
        alusel_cu   = 3'b000;
        shiftsel_cu = 2'b00;
        halted_cu   = (state_q == HALT);
        if (state_q == EXEC) begin
            rfaddr_cu = ir_q[2:0];
            case (opcode)
                4'h1: begin                             // LDA Rn
                    muxsel_cu = 2'b01;
                    accwr_cu  = 1'b1;
                end
                4'h2: rfwr_cu = 1'b1;                   // STA Rn
                4'h3: begin                             // LDI #imm
                    muxsel_cu = 2'b11;
                    imm_cu    = pm_data_cu;
                    accwr_cu  = 1'b1;
                end
                4'h4: begin                             // INA
                    muxsel_cu = 2'b10;
                    accwr_cu  = 1'b1;
                end
                4'h5: outen_cu = 1'b1;                  // OUT
                4'h6: begin alusel_cu = 3'b001; accwr_cu = 1'b1; end
                4'h7: begin alusel_cu = 3'b010; accwr_cu = 1'b1; end
                4'h8: begin alusel_cu = 3'b011; accwr_cu = 1'b1; end
                4'h9: begin alusel_cu = 3'b100; accwr_cu = 1'b1; end
                // NOT/INC/DEC are accumulator ops and write the result back.
                4'hA: begin alusel_cu = 3'b101; accwr_cu = 1'b1; end
                4'hB: begin
                    alusel_cu = ir_q[0] ? 3'b111 : 3'b110;
                    accwr_cu  = 1'b1;
                end
                4'hC: begin                             // SHF
                    shiftsel_cu = ir_q[1:0];
                    accwr_cu    = 1'b1;
                end
                // Branch keeps the shifter pass-through path selected so
                // the flags reflect the accumulator.
                4'hF: halted_cu = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_cu or negedge rst_cu) begin
        if (!rst_cu) begin
            state_q <= FETCH;
            pc_q    <= 5'd0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
`timescale 1ns/1ps

module tb_ctrl_unit;

    // ---------------- clock / reset ----------------
    logic       clk_cu = 1'b0;
    logic       rst_cu = 1'b0;
    always #5 clk_cu = ~clk_cu;

    logic [4:0] pm_addr_cu;
    logic [7:0] pm_data_cu;
    logic       zero_cu = 1'b0;
    logic       positive_cu = 1'b0;
    logic [1:0] muxsel_cu;
    logic [7:0] imm_cu;
    logic       accwr_cu, rfwr_cu, outen_cu;
    logic [2:0] rfaddr_cu, alusel_cu;
    logic [1:0] shiftsel_cu;
    logic       halted_cu;

`ifdef CU_SINGLESTEP_EN
    logic step_cu = 1'b1;
    localparam int CPI = 3;
`else
    localparam int CPI = 2;
`endif

    logic [7:0] pm [32];
    assign pm_data_cu = pm[pm_addr_cu];

    ctrl_unit dut (
        .clk_cu      (clk_cu),
        .rst_cu      (rst_cu),
`ifdef CU_SINGLESTEP_EN
        .step_cu     (step_cu),
`endif
        .pm_addr_cu  (pm_addr_cu),
        .pm_data_cu  (pm_data_cu),
        .zero_cu     (zero_cu),
        .positive_cu (positive_cu),
        .muxsel_cu   (muxsel_cu),
        .imm_cu      (imm_cu),
        .accwr_cu    (accwr_cu),
        .rfwr_cu     (rfwr_cu),
        .outen_cu    (outen_cu),
        .rfaddr_cu   (rfaddr_cu),
        .alusel_cu   (alusel_cu),
        .shiftsel_cu (shiftsel_cu),
        .halted_cu   (halted_cu)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h",
                     name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_pm();
        for (int i = 0; i < 32; i++) pm[i] = 8'h00;
    endtask

    // Hold reset across a rising edge, release just after it; cycle 1 is
    // the first FETCH, sampled on the following falling edge.
    task automatic start_run();
        rst_cu = 1'b0;
        @(posedge clk_cu);
        #1 rst_cu = 1'b1;
        @(negedge clk_cu);
        cyc = 1;
    endtask

    task automatic next_cycle();
        @(negedge clk_cu);
        cyc++;
    endtask

    // {muxsel, imm, accwr, rfwr, outen, rfaddr, alusel, shiftsel, halted}
    function automatic logic [21:0] pk(input logic [1:0] mux,
                                       input logic [7:0] imm,
                                       input logic acc, input logic rfw,
                                       input logic oen,
                                       input logic [2:0] rfa,
                                       input logic [2:0] alu,
                                       input logic [1:0] sh,
                                       input logic h);
        return {mux, imm, acc, rfw, oen, rfa, alu, sh, h};
    endfunction

    function automatic logic [21:0] dut_outs();
        return {muxsel_cu, imm_cu, accwr_cu, rfwr_cu, outen_cu, rfaddr_cu,
                alusel_cu, shiftsel_cu, halted_cu};
    endfunction

    function automatic logic [3:0] strobes();
        return {accwr_cu, rfwr_cu, outen_cu, halted_cu};
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        z;
        logic        p;
        logic [21:0] exp_exec;
        logic [4:0]  exp_next;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic z,
                                input logic p, input logic [21:0] e,
                                input logic [4:0] nx);
        vec_t v;
        v.name = n; v.b0 = b0; v.b1 = b1; v.z = z; v.p = p;
        v.exp_exec = e; v.exp_next = nx;
        return v;
    endfunction

    int acc_cnt, rfw_cnt, oen_cnt;

    initial begin
        // ---------------- vector table ----------------
        vecs.push_back(mk("nop",  8'h00, 8'hFF, 0, 0, pk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 5'd1));
        vecs.push_back(mk("lda",  8'h13, 8'hFF, 0, 0, pk(1, 8'h00, 1, 0, 0, 3, 0, 0, 0), 5'd1));
        vecs.push_back(mk("sta",  8'h25, 8'hFF, 0, 0, pk(0, 8'h00, 0, 1, 0, 5, 0, 0, 0), 5'd1));
        vecs.push_back(mk("ldi",  8'h3A, 8'h5C, 0, 0, pk(3, 8'h5C, 1, 0, 0, 2, 0, 0, 0), 5'd2));
        vecs.push_back(mk("ina",  8'h47, 8'hFF, 0, 0, pk(2, 8'h00, 1, 0, 0, 7, 0, 0, 0), 5'd1));
        vecs.push_back(mk("out",  8'h51, 8'hFF, 0, 0, pk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0), 5'd1));
        vecs.push_back(mk("add",  8'h62, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 2, 1, 0, 0), 5'd1));
        vecs.push_back(mk("sub",  8'h73, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 3, 2, 0, 0), 5'd1));
        vecs.push_back(mk("and",  8'h84, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 4, 3, 0, 0), 5'd1));
        vecs.push_back(mk("or",   8'h96, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 6, 4, 0, 0), 5'd1));
        vecs.push_back(mk("not",  8'hA0, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 0, 5, 0, 0), 5'd1));
        vecs.push_back(mk("inc",  8'hB0, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 0, 6, 0, 0), 5'd1));
        vecs.push_back(mk("dec",  8'hB1, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 1, 7, 0, 0), 5'd1));
        vecs.push_back(mk("shf2", 8'hC6, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 6, 0, 2, 0), 5'd1));
        vecs.push_back(mk("shf3", 8'hC3, 8'hFF, 0, 0, pk(0, 8'h00, 1, 0, 0, 3, 0, 3, 0), 5'd1));
        vecs.push_back(mk("jmp",  8'hD0, 8'h14, 0, 0, pk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 5'h14));
        vecs.push_back(mk("bz_t", 8'hE0, 8'h0A, 1, 0, pk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 5'h0A));
        vecs.push_back(mk("bz_n", 8'hE0, 8'h0A, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 5'h02));
        vecs.push_back(mk("bp_t", 8'hE1, 8'h0A, 0, 1, pk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0), 5'h0A));
        vecs.push_back(mk("bp_n", 8'hE1, 8'h0A, 1, 0, pk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0), 5'h02));
        vecs.push_back(mk("halt", 8'hF0, 8'hFF, 0, 0, pk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1), 5'd1));

        // ---------------- reset state ----------------
        clear_pm();
        #2;
        check("reset_addr", 32'(pm_addr_cu), 32'h0);
        check("reset_outs", 32'(dut_outs()), 32'h0);

        // ---------------- table-driven single instructions ----------------
        foreach (vecs[i]) begin
            clear_pm();
            pm[0] = vecs[i].b0;
            pm[1] = vecs[i].b1;
            zero_cu = vecs[i].z;
            positive_cu = vecs[i].p;
            start_run();
            check({vecs[i].name, "_fetch_addr"}, 32'(pm_addr_cu), 32'h0);
            check({vecs[i].name, "_fetch_strb"}, 32'(strobes()), 32'h0);
            next_cycle();
            check({vecs[i].name, "_exec"}, 32'(dut_outs()), 32'(vecs[i].exp_exec));
            next_cycle();
            check({vecs[i].name, "_next_addr"}, 32'(pm_addr_cu), 32'(vecs[i].exp_next));
        end
        zero_cu = 1'b0;
        positive_cu = 1'b0;

        // ---------------- program: LDI 05, STA R2, ADD R2, OUT, HALT ----------------
        clear_pm();
        pm[0] = 8'h30; pm[1] = 8'h05; pm[2] = 8'h22; pm[3] = 8'h62;
        pm[4] = 8'h50; pm[5] = 8'hF0;
        acc_cnt = 0; rfw_cnt = 0; oen_cnt = 0;
        start_run();
        while (cyc <= 4 * CPI + 5) begin
            acc_cnt += int'(accwr_cu);
            rfw_cnt += int'(rfwr_cu);
            oen_cnt += int'(outen_cu);
            if (cyc == 2) begin
                check("prog_ldi", 32'({imm_cu, accwr_cu, muxsel_cu}), 32'({8'h05, 1'b1, 2'b11}));
            end
            if (cyc == CPI + 2) begin
                check("prog_sta", 32'({rfwr_cu, rfaddr_cu}), 32'({1'b1, 3'd2}));
            end
            if (cyc == 2 * CPI + 2) begin
                check("prog_add", 32'({accwr_cu, alusel_cu}), 32'({1'b1, 3'b001}));
            end
            if (cyc == 3 * CPI + 2) begin
                check("prog_out", 32'(outen_cu), 32'h1);
            end
            if (cyc == 4 * CPI + 1) begin
                check("prog_prehalt", 32'(halted_cu), 32'h0);
            end
            if (cyc >= 4 * CPI + 2) begin
                check("prog_halted", 32'({halted_cu, pm_addr_cu}), 32'({1'b1, 5'd6}));
            end
            next_cycle();
        end
        check("prog_accwr_pulses", 32'(acc_cnt), 32'd2);
        check("prog_rfwr_pulses", 32'(rfw_cnt), 32'd1);
        check("prog_outen_pulses", 32'(oen_cnt), 32'd1);

        // reset while halted releases the unit immediately
        #2 rst_cu = 1'b0;
        #1;
        check("halt_rst_addr", 32'(pm_addr_cu), 32'h0);
        check("halt_rst_outs", 32'(dut_outs()), 32'h0);
        @(posedge clk_cu);
        #1 rst_cu = 1'b1;
        @(negedge clk_cu);
        cyc = 1;
        check("halt_rst_refetch", 32'({pm_addr_cu, halted_cu}), 32'({5'd0, 1'b0}));

        // ---------------- JMP to 1F, NOP at 1F, wrap to 00 ----------------
        clear_pm();
        pm[0] = 8'hD0; pm[1] = 8'h1F; pm[31] = 8'h00;
        start_run();
        while (cyc <= 2 * CPI + 1) begin
            if (cyc == CPI + 1) check("jmp_fetch_1f", 32'(pm_addr_cu), 32'h1F);
            if (cyc == 2 * CPI + 1) check("wrap_fetch_00", 32'(pm_addr_cu), 32'h00);
            next_cycle();
        end

        // ---------------- BP not taken at 1E, operand at 1F ----------------
        clear_pm();
        pm[0] = 8'hD0; pm[1] = 8'h1E; pm[30] = 8'hE1; pm[31] = 8'h0A;
        positive_cu = 1'b0;
        zero_cu = 1'b1;
        start_run();
        while (cyc <= 2 * CPI + 1) begin
            if (cyc == CPI + 1) check("bp_fetch_1e", 32'(pm_addr_cu), 32'h1E);
            if (cyc == CPI + 2) check("bp_operand_1f", 32'(pm_addr_cu), 32'h1F);
            if (cyc == 2 * CPI + 1) check("bp_wrap_00", 32'(pm_addr_cu), 32'h00);
            next_cycle();
        end
        zero_cu = 1'b0;

        // ---------------- reset during EXEC of LDI ----------------
        clear_pm();
        pm[0] = 8'h30; pm[1] = 8'h05;
        start_run();
        next_cycle();
        check("ldi_exec_acc", 32'({accwr_cu, pm_addr_cu}), 32'({1'b1, 5'd1}));
        #2 rst_cu = 1'b0;
        #1;
        check("ldi_rst_outs", 32'(dut_outs()), 32'h0);
        check("ldi_rst_addr", 32'(pm_addr_cu), 32'h0);
        @(posedge clk_cu);
        #1 rst_cu = 1'b1;
        @(negedge clk_cu);
        cyc = 1;
        check("ldi_refetch_addr", 32'(pm_addr_cu), 32'h0);
        next_cycle();
        check("ldi_reexec", 32'({accwr_cu, imm_cu}), 32'({1'b1, 8'h05}));

`ifdef CU_SINGLESTEP_EN
        // ---------------- single step: park, then release one instruction ----------------
        clear_pm();
        pm[0] = 8'h13; pm[1] = 8'h25; pm[2] = 8'hF0;
        step_cu = 1'b0;
        start_run();
        next_cycle();
        check("ss_lda", 32'(accwr_cu), 32'h1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check("ss_parked", 32'({strobes(), pm_addr_cu}), 32'({4'h0, 5'd1}));
        end
        step_cu = 1'b1;
        next_cycle();
        step_cu = 1'b0;
        check("ss_fetch", 32'({strobes(), pm_addr_cu}), 32'({4'h0, 5'd1}));
        next_cycle();
        check("ss_sta", 32'({rfwr_cu, rfaddr_cu}), 32'({1'b1, 3'd5}));
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check("ss_parked2", 32'({strobes(), pm_addr_cu}), 32'({4'h0, 5'd2}));
        end
        step_cu = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
